// File: rtl/fft_twiddle_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_twiddle_feeder_pkg
//  Description : Shared widths, FSM encodings and the elaboration-time twiddle
//                generator used by the FFT twiddle feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_twiddle_feeder_pkg;

    localparam int FLOAT_LEN = 32;
    localparam int CPLX_W    = 2 * FLOAT_LEN;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Fixed-point format used while generating twiddles: Q60 in a signed 128-bit word.
    localparam int                  FRAC  = 60;
    localparam logic signed [127:0] Q_ONE = 128'sd1 <<< FRAC;
    localparam logic signed [127:0] PI_Q  = 128'sh3243F6A8885A308D;

    // Round a Q60 value to the nearest single-precision float (ties to even).
    function automatic logic [31:0] q_to_f32(input logic signed [127:0] v);
        logic [127:0] mag;
        logic [127:0] mant;
        logic [127:0] rem;
        logic [127:0] half;
        logic [127:0] one;
        logic         sign;
        int           p;
        int           ex;
        int           sh;
        one  = 128'd1;
        sign = v[127];
        mag  = sign ? 128'(-v) : 128'(v);
        mant = '0;
        if (mag == '0) begin
            return 32'd0;
        end
        p = 0;
        for (int b = 0; b < 127; b++) begin
            if (mag[b]) p = b;
        end
        ex = 127 + p - FRAC;
        if (p > 23) begin
            sh   = p - 23;
            mant = mag >> sh;
            rem  = mag & ((one << sh) - one);
            half = one << (sh - 1);
            if ((rem > half) || ((rem == half) && mant[0])) begin
                mant = mant + one;
            end
        end else begin
            mant = mag << (23 - p);
        end
        if (mant[24]) begin
            mant = mant >> 1;
            ex   = ex + 1;
        end
        return {sign, ex[7:0], mant[22:0]};
    endfunction

    // Twiddle W_N^e = {cos(2*pi*e/N), -sin(2*pi*e/N)} for 0 <= e < N/2, N >= 8.
    // The angle is folded into [0, pi/4] so a short Taylor series is exact to
    // far below single precision, and the axis points come out as exact 0/1.
    function automatic logic [63:0] twiddle_word(input int e, input int log2n);
        int                  n;
        int                  quarter;
        int                  eighth;
        int                  i;
        int                  j;
        logic                quad;
        logic                swap;
        logic signed [127:0] x;
        logic signed [127:0] x2;
        logic signed [127:0] term;
        logic signed [127:0] sin_x;
        logic signed [127:0] cos_x;
        logic signed [127:0] ca;
        logic signed [127:0] sa;
        logic signed [127:0] c_t;
        logic signed [127:0] s_t;
        logic signed [127:0] den;
        n       = 1 << log2n;
        quarter = n / 4;
        eighth  = n / 8;
        quad    = (e >= quarter);
        i       = quad ? (e - quarter) : e;
        swap    = (i > eighth);
        j       = swap ? (quarter - i) : i;
        x       = (PI_Q * 128'(2 * j)) / 128'(n);
        x2      = (x * x) >>> FRAC;
        term    = x;
        sin_x   = x;
        for (int t = 1; t < 16; t++) begin
            den   = 128'(2 * t * (2 * t + 1));
            term  = -((term * x2) >>> FRAC) / den;
            sin_x = sin_x + term;
        end
        term  = Q_ONE;
        cos_x = Q_ONE;
        for (int t = 1; t < 16; t++) begin
            den   = 128'((2 * t - 1) * (2 * t));
            term  = -((term * x2) >>> FRAC) / den;
            cos_x = cos_x + term;
        end
        ca  = swap ? sin_x : cos_x;
        sa  = swap ? cos_x : sin_x;
        c_t = quad ? -sa : ca;
        s_t = quad ? ca : sa;
        return {q_to_f32(c_t), q_to_f32(-s_t)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_twiddle_feeder_rom.sv
`default_nettype none
// ============================================================================
//  Module      : fft_twiddle_feeder_rom
//  Description : N/2-entry twiddle ROM, contents fixed at elaboration,
//                one-cycle registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_twiddle_feeder_rom
    import fft_twiddle_feeder_pkg::*;
#(
    parameter int LOG2N = 10
) (
    input  logic                 clk,
    input  logic [LOG2N-2:0]     addr,
    output logic [CPLX_W-1:0]    data
);

    localparam int DEPTH = 1 << (LOG2N - 1);

    logic [CPLX_W-1:0] rom_w [DEPTH];
    logic [CPLX_W-1:0] data_d;
    logic [CPLX_W-1:0] data_q;

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        localparam logic [CPLX_W-1:0] WORD = twiddle_word(e, LOG2N);
        assign rom_w[e] = WORD;
    end

    // Combinational lookup of the addressed twiddle.
    always_comb begin
        data_d = rom_w[addr];
    end

    // Synchronous read register; no reset so it maps onto block ROM.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/fft_twiddle_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : fft_twiddle_feeder
//  Description : Pairs each lower-leg butterfly sample of a radix-2 DIT stage
//                with its twiddle factor and presents both, aligned and
//                registered, to the complex multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_twiddle_feeder
    import fft_twiddle_feeder_pkg::*;
#(
    parameter int LOG2N = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LOG2N-1:0]     stage,
    input  logic [CPLX_W-1:0]    data_in,
    input  logic                 data_in_valid,
    output logic [CPLX_W-1:0]    data_out_x,
    output logic [CPLX_W-1:0]    data_out_w,
    output logic                 data_out_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int               AW     = LOG2N - 1;
    localparam logic [AW-1:0]    K_LAST = '1;
    localparam logic [LOG2N-1:0] S_MAX  = LOG2N'(LOG2N - 1);

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     k_q, k_d;
    logic [LOG2N-1:0]  s_q, s_d;
    logic [CPLX_W-1:0] x1_q, x1_d;
    logic              v1_q, v1_d;
    logic              last1_q, last1_d;
    logic [CPLX_W-1:0] x_q, x_d;
    logic [CPLX_W-1:0] w_q, w_d;
    logic              v_q, v_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              w_accept;
    logic [AW-1:0]     w_mask;
    logic [LOG2N-1:0]  w_shamt;
    logic [AW-1:0]     w_addr;
    logic [CPLX_W-1:0] w_rom_data;

    // Twiddle address: low s bits of k, scaled up to the full N/2 index range.
    // For s = LOG2N-1 the mask wraps to all ones and the shift is zero.
    always_comb begin
        w_accept = (state_q == ST_RUN) && data_in_valid;
        w_mask   = (AW'(1) << s_q) - AW'(1);
        w_shamt  = LOG2N'(AW) - s_q;
        w_addr   = (k_q & w_mask) << w_shamt;
    end

    fft_twiddle_feeder_rom #(
        .LOG2N (LOG2N)
    ) u_rom (
        .clk  (clk),
        .addr (w_addr),
        .data (w_rom_data)
    );

    // Pass control, k counter and the two-stage sample/valid alignment pipeline.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                    s_d     = (stage > S_MAX) ? S_MAX : stage;
                end
            end
            ST_RUN: begin
                if (data_in_valid) begin
                    k_d = k_q + AW'(1);
                    if (k_q == K_LAST) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (v1_q && last1_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        x1_d    = data_in;
        v1_d    = w_accept;
        last1_d = w_accept && (k_q == K_LAST);

        x_d     = x1_q;
        w_d     = w_rom_data;
        v_d     = v1_q;
        done_d  = v1_q && last1_q;
        busy_d  = (state_d != ST_IDLE) || done_d;
    end

    // State and pipeline registers; reset aborts any pass in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            s_q     <= '0;
            x1_q    <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            x_q     <= '0;
            w_q     <= '0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            x1_q    <= x1_d;
            v1_q    <= v1_d;
            last1_q <= last1_d;
            x_q     <= x_d;
            w_q     <= w_d;
            v_q     <= v_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out_x     = x_q;
    assign data_out_w     = w_q;
    assign data_out_valid = v_q;
    assign done           = done_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire
